// File: rtl/pomdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pomdp_pkg
//  Description : Shared constants and types for the two-state POMDP belief
//                updater: FSM state encoding, probability width, reset and
//                clamp bounds for the belief value.
//  Revision    : 1.0 - initial release
// ============================================================================
package pomdp_pkg;

    localparam int NUM_ACTIONS = 3;
    localparam int NUM_STATES  = 2;
    localparam int PROB_W      = 16;

    localparam logic [PROB_W-1:0] BELIEF_MIN   = 16'h0040;
    localparam logic [PROB_W-1:0] BELIEF_RESET = 16'h8000;

    // Number of quotient bits produced by the divider, one per cycle.
    localparam int DIV_STEPS = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRED = 3'd1,
        ST_LIK  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/belief_update_if.sv
`default_nettype none
// ============================================================================
//  Module      : belief_update_if
//  Description : Bus between the observation generator (master) and the
//                belief updater (slave).
//                  en_belief   - start pulse
//                  observation - observed symbol o
//                  action      - action index a (0..2 valid)
//                  trans       - Q0.16, trans[a][s][s']
//                  observe     - Q0.16, observe[a][s'][o]
//                  init_load / init_belief - belief load strobe and value
//                  belief / belief_valid / busy / err - results and status
//  Revision    : 1.0 - initial release
// ============================================================================
interface belief_update_if;
    import pomdp_pkg::*;

    logic                   en_belief;
    logic                   observation;
    logic [1:0]             action;
    logic [0:NUM_ACTIONS-1][0:NUM_STATES-1][0:1][PROB_W-1:0] trans;
    logic [0:NUM_ACTIONS-1][0:NUM_STATES-1][0:1][PROB_W-1:0] observe;
    logic                   init_load;
    logic [PROB_W-1:0]      init_belief;
    logic [PROB_W-1:0]      belief;
    logic                   belief_valid;
    logic                   busy;
    logic                   err;

    modport master (
        output en_belief, observation, action, trans, observe,
               init_load, init_belief,
        input  belief, belief_valid, busy, err
    );

    modport slave (
        input  en_belief, observation, action, trans, observe,
               init_load, init_belief,
        output belief, belief_valid, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/belief_div.sv
`default_nettype none
// ============================================================================
//  Module      : belief_div
//  Description : Restoring divider computing floor(dividend * 2^16 / divisor)
//                one quotient bit per cycle over 16 cycles. The result
//                saturates to 0xFFFF whenever dividend >= divisor (which
//                includes divisor == 0).
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                i_start          - load operands and begin
//                i_dividend/i_divisor - 33-bit operands
//                o_done           - high during the final iteration cycle;
//                                   o_quotient is final after that edge
//                o_quotient       - 16-bit saturating quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module belief_div
    import pomdp_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_start,
    input  wire logic [32:0] i_dividend,
    input  wire logic [32:0] i_divisor,
    output logic             o_done,
    output logic [15:0]      o_quotient
);

    logic        r_run;
    logic [3:0]  r_cnt;
    logic [32:0] r_rem;
    logic [32:0] r_dsr;
    logic [15:0] r_q;
    logic        r_sat;

    logic [33:0] w_shift;
    logic        w_ge;
    logic [32:0] w_diff;

    // When not saturated the remainder stays below the divisor, so the
    // shifted value fits 34 bits and the difference fits 33.
    assign w_shift = {r_rem, 1'b0};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_diff  = w_shift[32:0] - r_dsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= 4'd0;
            r_rem <= 33'd0;
            r_dsr <= 33'd0;
            r_q   <= 16'd0;
            r_sat <= 1'b0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= 4'd0;
            r_rem <= i_dividend;
            r_dsr <= i_divisor;
            r_q   <= 16'd0;
            r_sat <= (i_dividend >= i_divisor);
        end else if (r_run) begin
            r_rem <= w_ge ? w_diff : w_shift[32:0];
            r_q   <= {r_q[14:0], w_ge};
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'(DIV_STEPS - 1)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign o_done     = r_run && (r_cnt == 4'(DIV_STEPS - 1));
    assign o_quotient = r_sat ? 16'hFFFF : r_q;

endmodule
`default_nettype wire

// File: rtl/belief_update.sv
`default_nettype none
// ============================================================================
//  Module      : belief_update
//  Description : Two-state POMDP Bayesian belief update.
//                IDLE -> PRED (prediction through trans) -> LIK (weight by
//                observe) -> DIV (16-cycle normalisation) -> DONE -> IDLE.
//                belief_valid rises 19 edges after the edge sampling
//                en_belief. Zero normaliser or action 3 leaves belief
//                unchanged and pulses err with belief_valid.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - belief_update_if.slave
//  Options     : BELIEF_CLAMP_EN - clamp the updated belief to
//                [BELIEF_MIN, 0xFFFF - BELIEF_MIN]
//  Revision    : 1.0 - initial release
// ============================================================================
module belief_update
    import pomdp_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    belief_update_if.slave   bus
);

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_action;
    logic        r_obs;
    logic [15:0] r_b0;
    logic [15:0] r_p0;
    logic        r_den_zero;
    logic [15:0] r_belief;
    logic        r_valid;
    logic        r_err;

    logic        w_div_start;
    logic        w_div_done;
    logic [15:0] w_q;
    logic [15:0] w_new;

    // Action 3 is flagged as an error at DONE; the pipeline still runs with
    // a legal table index so the latency is identical.
    logic [1:0]  w_a_idx;
    assign w_a_idx = (r_action == 2'd3) ? 2'd0 : r_action;

    // Prediction: p0 = (b0*T[a][0][0] + b1*T[a][1][0]) >> 16, saturating.
    logic [15:0] w_b1;
    logic [31:0] w_bt0;
    logic [31:0] w_bt1;
    logic [32:0] w_sum;
    logic [32:0] w_shr;
    logic [15:0] w_p0;

    assign w_b1  = 16'hFFFF - r_b0;
    assign w_bt0 = {16'd0, r_b0} * {16'd0, bus.trans[w_a_idx][0][0]};
    assign w_bt1 = {16'd0, w_b1} * {16'd0, bus.trans[w_a_idx][1][0]};
    assign w_sum = {1'b0, w_bt0} + {1'b0, w_bt1};
    assign w_shr = w_sum >> 16;
    assign w_p0  = (w_shr > 33'h0FFFF) ? 16'hFFFF : w_shr[15:0];

    // Likelihood weighting and normaliser.
    logic [15:0] w_p1;
    logic [31:0] w_u0;
    logic [31:0] w_u1;
    logic [32:0] w_den;

    assign w_p1  = 16'hFFFF - r_p0;
    assign w_u0  = {16'd0, r_p0} * {16'd0, bus.observe[w_a_idx][0][r_obs]};
    assign w_u1  = {16'd0, w_p1} * {16'd0, bus.observe[w_a_idx][1][r_obs]};
    assign w_den = {1'b0, w_u0} + {1'b0, w_u1};

    belief_div u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend ({1'b0, w_u0}),
        .i_divisor  (w_den),
        .o_done     (w_div_done),
        .o_quotient (w_q)
    );

`ifdef BELIEF_CLAMP_EN
    assign w_new = (w_q < BELIEF_MIN)            ? BELIEF_MIN :
                   (w_q > (16'hFFFF - BELIEF_MIN)) ? (16'hFFFF - BELIEF_MIN) :
                   w_q;
`else
    assign w_new = w_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en_belief && !bus.init_load) begin
                    w_next = ST_PRED;
                end
            end
            ST_PRED: w_next = ST_LIK;
            ST_LIK: begin
                w_div_start = 1'b1;
                w_next      = ST_DIV;
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_action   <= 2'd0;
            r_obs      <= 1'b0;
            r_b0       <= BELIEF_RESET;
            r_p0       <= 16'd0;
            r_den_zero <= 1'b0;
            r_belief   <= BELIEF_RESET;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.init_load) begin
                        r_belief <= bus.init_belief;
                    end else if (bus.en_belief) begin
                        r_action <= bus.action;
                        r_obs    <= bus.observation;
                        r_b0     <= r_belief;
                    end
                end
                ST_PRED: r_p0 <= w_p0;
                ST_LIK:  r_den_zero <= (w_den == 33'd0);
                ST_DONE: begin
                    r_valid <= 1'b1;
                    if (r_den_zero || (r_action == 2'd3)) begin
                        r_err <= 1'b1;
                    end else begin
                        r_belief <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.belief       = r_belief;
    assign bus.belief_valid = r_valid;
    assign bus.err          = r_err;
    assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_belief_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_belief_update
//  Description : Self-checking bench for belief_update. Expected belief/err
//                and start cycle are queued when a run is launched and
//                compared when belief_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_belief_update;
    import pomdp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    belief_update_if bif();

    belief_update dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [15:0] b;
        logic        e;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_valid  = 0;
    logic [15:0] model_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model written straight from the update equations.
    function automatic logic [16:0] model(input logic [15:0] b0, input logic [1:0] a, input logic o);
        longint unsigned x0, x1, s, p0, p1, u0, u1, den, q;
        if (a == 2'd3) return {1'b1, b0};
        x0  = b0;
        x1  = 65535 - x0;
        s   = x0 * bif.trans[a][0][0] + x1 * bif.trans[a][1][0];
        p0  = s >> 16;
        if (p0 > 65535) p0 = 65535;
        p1  = 65535 - p0;
        u0  = p0 * bif.observe[a][0][o];
        u1  = p1 * bif.observe[a][1][o];
        den = u0 + u1;
        if (den == 0) return {1'b1, b0};
        q = (u0 << 16) / den;
        if (q > 65535) q = 65535;
`ifdef BELIEF_CLAMP_EN
        if (q < 64) q = 64;
        if (q > 65471) q = 65471;
`endif
        return {1'b0, q[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!rst && bif.belief_valid) begin
            exp_t e;
            n_valid++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_valid got=1 exp=0");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                assert (bif.belief === e.b) else begin
                    n_errors++;
                    $error("FAIL belief got=%0h exp=%0h", bif.belief, e.b);
                end
                n_checks++;
                assert (bif.err === e.e) else begin
                    n_errors++;
                    $error("FAIL err got=%0b exp=%0b", bif.err, e.e);
                end
                n_checks++;
                assert ((cyc - e.c) == 19) else begin
                    n_errors++;
                    $error("FAIL latency got=%0d exp=19", cyc - e.c);
                end
            end
        end
    end

    task automatic start_op(input logic [1:0] a, input logic o);
        logic [16:0] m;
        @(negedge clk);
        bif.action      = a;
        bif.observation = o;
        bif.en_belief   = 1'b1;
        m = model(model_b, a, o);
        sb.push_back('{m[15:0], m[16], cyc + 1});
        if (!m[16]) model_b = m[15:0];
        @(negedge clk);
        bif.en_belief = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL timeout got=%0d pending exp=0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        bif.init_load   = 1'b1;
        bif.init_belief = v;
        @(negedge clk);
        bif.init_load = 1'b0;
        model_b = v;
        chk("init_load", {16'd0, bif.belief}, {16'd0, v});
    endtask

    initial begin
        int v0;
        logic [15:0] keep;
        bif.en_belief   = 1'b0;
        bif.observation = 1'b0;
        bif.action      = 2'd0;
        bif.init_load   = 1'b0;
        bif.init_belief = 16'd0;
        for (int a = 0; a < 3; a++) begin
            bif.trans[a][0][0] = 16'hFFFF; bif.trans[a][0][1] = 16'h0000;
            bif.trans[a][1][0] = 16'h0000; bif.trans[a][1][1] = 16'hFFFF;
            for (int s = 0; s < 2; s++)
                for (int o = 0; o < 2; o++)
                    bif.observe[a][s][o] = 16'h4000;
        end
        model_b = 16'h8000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_belief", {16'd0, bif.belief}, 32'h8000);
        chk("rst_valid",  {31'd0, bif.belief_valid}, 32'd0);
        chk("rst_busy",   {31'd0, bif.busy}, 32'd0);
        chk("rst_err",    {31'd0, bif.err}, 32'd0);
        rst = 1'b0;

        // Identity transitions, equal likelihoods
        start_op(2'd0, 1'b0);
        chk("busy_run", {31'd0, bif.busy}, 32'd1);
        wait_done(40);
        chk("ident_belief", {16'd0, bif.belief}, 32'h7FFF);
        chk("idle_busy", {31'd0, bif.busy}, 32'd0);

        // Zero likelihood for state 1 -> saturated quotient
        load(16'h8000);
        bif.observe[1][1][1] = 16'h0000;
        bif.observe[1][0][1] = 16'h8000;
        start_op(2'd1, 1'b1);
        wait_done(40);
`ifdef BELIEF_CLAMP_EN
        chk("sat_belief", {16'd0, bif.belief}, 32'hFFBF);
`else
        chk("sat_belief", {16'd0, bif.belief}, 32'hFFFF);
`endif

        // Random tables on action 2
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++)
                for (int o = 0; o < 2; o++) begin
                    bif.trans[2][s][o]   = 16'($urandom);
                    bif.observe[2][s][o] = 16'($urandom);
                end
            load(16'($urandom));
            start_op(2'd2, i[0]);
            wait_done(40);
        end

        // Zero normaliser
        keep = model_b;
        bif.observe[0][0][0] = 16'h0000;
        bif.observe[0][1][0] = 16'h0000;
        start_op(2'd0, 1'b0);
        wait_done(40);
        chk("den0_keep", {16'd0, bif.belief}, {16'd0, keep});
        bif.observe[0][0][0] = 16'h4000;
        bif.observe[0][1][0] = 16'h4000;

        // Invalid action
        start_op(2'd3, 1'b0);
        wait_done(40);
        chk("act3_keep", {16'd0, bif.belief}, {16'd0, keep});

        // Second start while busy is ignored
        v0 = n_valid;
        start_op(2'd0, 1'b1);
        repeat (4) @(negedge clk);
        bif.en_belief = 1'b1;
        @(negedge clk);
        bif.en_belief = 1'b0;
        wait_done(40);
        repeat (25) @(negedge clk);
        chk("one_valid", n_valid - v0, 32'd1);

        // Reset in the middle of DIV
        start_op(2'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        model_b = 16'h8000;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_belief", {16'd0, bif.belief}, 32'h8000);
        chk("abort_busy",   {31'd0, bif.busy}, 32'd0);
        start_op(2'd0, 1'b0);
        wait_done(40);
        chk("after_rst", {16'd0, bif.belief}, 32'h7FFF);

        // init_load wins over a simultaneous start
        @(negedge clk);
        bif.init_load   = 1'b1;
        bif.init_belief = 16'h1234;
        bif.en_belief   = 1'b1;
        @(negedge clk);
        bif.init_load = 1'b0;
        bif.en_belief = 1'b0;
        model_b = 16'h1234;
        chk("load_win_belief", {16'd0, bif.belief}, 32'h1234);
        chk("load_win_busy",   {31'd0, bif.busy}, 32'd0);
        repeat (25) @(negedge clk);
        chk("load_win_idle",   {31'd0, bif.busy}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
